// File: rtl/fir_decim_fifo.sv
// Post-FIR settle/decimate stage feeding a show-ahead FIFO with valid/ready output and sticky overflow.
// Optional drop counter output OvfCnt is enabled by defining FIR_DECIM_OVF_CNT_EN.
module fir_decim_fifo #(
   parameter int DW     = 12,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 16,
   parameter int SETTLE = 32
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic                       En,
   input  logic [DW-1:0]              Din,
   input  logic                       Din_vld,
   output logic [DW-1:0]              Dout,
   output logic                       Dout_vld,
   input  logic                       Dout_rdy,
   output logic [$clog2(DEPTH):0]     Level,
   output logic                       Ovf,
   input  logic                       Ovf_clr
`ifdef FIR_DECIM_OVF_CNT_EN
   ,output logic [15:0]               OvfCnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [PW-1:0] PHASE_LAST  = PW'(DECIM - 1);
   localparam logic [LW-1:0] LEVEL_FULL  = LW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q;
   logic [DW-1:0]   mem [DEPTH];

   logic keep, full, empty, pop, push, drop;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      phase_d  = phase_q;
      keep     = 1'b0;
      if (!En) begin
         state_d  = S_IDLE;
         settle_d = '0;
         phase_d  = '0;
      end else begin
         case (state_q)
            S_IDLE:   state_d = (SETTLE == 0) ? S_RUN : S_SETTLE;
            S_SETTLE: if (Din_vld) begin
               // The sample that completes the settle count is itself discarded.
               if (settle_q == SETTLE_LAST) begin
                  state_d  = S_RUN;
                  settle_d = '0;
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end
            S_RUN:    if (Din_vld) begin
               keep    = (phase_q == '0);
               phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            end
            default:  state_d = S_IDLE;
         endcase
      end
   end

   assign full  = (level_q == LEVEL_FULL);
   assign empty = (level_q == '0);
   assign pop   = !empty && Dout_rdy;
   assign push  = keep && (!full || pop);
   assign drop  = keep && full && !pop;

   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         phase_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         phase_q  <= phase_d;
         level_q  <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         ovf_q    <= drop || (ovf_q && !Ovf_clr);
      end
   end

   // Storage needs no reset: occupancy is tracked solely by level_q.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr_q] <= Din;
   end

   assign Dout     = empty ? '0 : mem[rd_ptr_q];
   assign Dout_vld = !empty;
   assign Level    = level_q;
   assign Ovf      = ovf_q;

`ifdef FIR_DECIM_OVF_CNT_EN
   logic [15:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (Ovf_clr)                         ovf_cnt_d = drop ? 16'd1 : 16'd0;
      else if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) ovf_cnt_q <= '0;
      else        ovf_cnt_q <= ovf_cnt_d;
   end

   assign OvfCnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: a reference model feeds a scoreboard queue that is checked every cycle.
// Instance u_dut uses the default parameters; u_dut1 uses DECIM=1, SETTLE=0.
module tb_fir_decim_fifo;
   localparam int DW = 12, DECIM = 4, DEPTH = 16, SETTLE = 32;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic          En, Din_vld, Dout_rdy, Ovf_clr;
   logic [DW-1:0] Din;
   logic [DW-1:0] Dout;
   logic          Dout_vld, Ovf;
   logic [4:0]    Level;
   logic          En1, Din_vld1, Dout_rdy1;
   logic [DW-1:0] Din1, Dout1;
   logic          Dout_vld1, Ovf1;
   logic [4:0]    Level1;
`ifdef FIR_DECIM_OVF_CNT_EN
   logic [15:0]   OvfCnt, OvfCnt1;
`endif

   always #5 Clk = ~Clk;

   fir_decim_fifo #(.DW(DW), .DECIM(DECIM), .DEPTH(DEPTH), .SETTLE(SETTLE)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .Din(Din), .Din_vld(Din_vld),
      .Dout(Dout), .Dout_vld(Dout_vld), .Dout_rdy(Dout_rdy), .Level(Level),
      .Ovf(Ovf), .Ovf_clr(Ovf_clr)
`ifdef FIR_DECIM_OVF_CNT_EN
      , .OvfCnt(OvfCnt)
`endif
   );

   fir_decim_fifo #(.DW(DW), .DECIM(1), .DEPTH(DEPTH), .SETTLE(0)) u_dut1 (
      .Clk(Clk), .Rst_n(Rst_n), .En(En1), .Din(Din1), .Din_vld(Din_vld1),
      .Dout(Dout1), .Dout_vld(Dout_vld1), .Dout_rdy(Dout_rdy1), .Level(Level1),
      .Ovf(Ovf1), .Ovf_clr(Ovf_clr)
`ifdef FIR_DECIM_OVF_CNT_EN
      , .OvfCnt(OvfCnt1)
`endif
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int en_cyc = 0;
   int first_vld = -1;
   int pops1 = 0;

   // Reference model state
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] sb1_q[$];
   int  m_state = 0;   // 0 idle, 1 settle, 2 run
   int  m_scnt = 0, m_phase = 0, m_cnt = 0;
   bit  m_ovf = 0, m1_run = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete(); sb1_q.delete();
      m_state = 0; m_scnt = 0; m_phase = 0; m_cnt = 0; m_ovf = 0; m1_run = 0;
   endtask

   // One clock: check outputs at negedge against the model, advance the model, then step past posedge.
   task automatic tick();
      bit keep, pop, drop, pop1;
      @(negedge Clk);
      chk("vld", 32'(Dout_vld), 32'(sb_q.size() != 0));
      chk("level", 32'(Level), 32'(sb_q.size()));
      chk("ovf", 32'(Ovf), 32'(m_ovf));
      if (sb_q.size() != 0) chk("dout", 32'(Dout), 32'(sb_q[0]));
`ifdef FIR_DECIM_OVF_CNT_EN
      chk("ovfcnt", 32'(OvfCnt), 32'(m_cnt));
`endif
      chk("vld1", 32'(Dout_vld1), 32'(sb1_q.size() != 0));
      chk("level1", 32'(Level1), 32'(sb1_q.size()));
      if (sb1_q.size() != 0) chk("dout1", 32'(Dout1), 32'(sb1_q[0]));
      if (Dout_vld === 1'b1 && first_vld < 0) first_vld = cyc - en_cyc;

      if (!Rst_n) begin
         model_reset();
      end else begin
         keep = 0;
         if (!En) begin
            m_state = 0; m_scnt = 0; m_phase = 0;
         end else if (m_state == 0) begin
            m_state = (SETTLE == 0) ? 2 : 1;
         end else if (m_state == 1) begin
            if (Din_vld) begin
               if (m_scnt == SETTLE - 1) begin m_state = 2; m_scnt = 0; end
               else m_scnt++;
            end
         end else if (Din_vld) begin
            keep = (m_phase == 0);
            m_phase = (m_phase + 1) % DECIM;
         end
         pop  = (sb_q.size() != 0) && Dout_rdy;
         drop = keep && (sb_q.size() == DEPTH) && !pop;
         if (pop) void'(sb_q.pop_front());
         if (keep && !drop) sb_q.push_back(Din);
         m_ovf = drop || (m_ovf && !Ovf_clr);
         if (Ovf_clr) m_cnt = drop ? 1 : 0;
         else if (drop && m_cnt != 16'hFFFF) m_cnt++;

         pop1 = (sb1_q.size() != 0) && Dout_rdy1;
         if (pop1) begin void'(sb1_q.pop_front()); pops1++; end
         if (m1_run && En1 && Din_vld1) sb1_q.push_back(Din1);
         m1_run = En1;
      end
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   initial begin
      int n;
      Rst_n = 1'b0; En = 0; Din = '0; Din_vld = 0; Dout_rdy = 0; Ovf_clr = 0;
      En1 = 0; Din1 = '0; Din_vld1 = 0; Dout_rdy1 = 0;
      #1;
      chk("rst_dout", 32'(Dout), 32'd0);
      chk("rst_vld", 32'(Dout_vld), 32'd0);
      chk("rst_level", 32'(Level), 32'd0);
      chk("rst_ovf", 32'(Ovf), 32'd0);
      tick(); tick();
      Rst_n = 1'b1;
      tick();

      // Settle then decimate: expect 32,36,40,... and first valid 34 cycles after En
      En = 1; Dout_rdy = 1; en_cyc = cyc; first_vld = -1;
      tick();
      for (int i = 0; i < 72; i++) begin
         Din = DW'(i); Din_vld = 1; tick();
      end
      Din_vld = 0;
      chk("first_vld_latency", 32'(first_vld), 32'd34);
      for (int i = 0; i < 4; i++) tick();
      chk("drained", 32'(Level), 32'd0);

      // Stall: 20 kept samples into a 16-deep FIFO
      Dout_rdy = 0;
      for (int i = 0; i < 80; i++) begin
         Din = DW'(100 + i); Din_vld = 1; tick();
      end
      chk("stall_level", 32'(Level), 32'd16);
      chk("stall_ovf", 32'(Ovf), 32'd1);
`ifdef FIR_DECIM_OVF_CNT_EN
      chk("stall_ovfcnt", 32'(OvfCnt), 32'd4);
`endif

      // Full push+pop on a kept sample: no drop
      Dout_rdy = 1; Din = 12'h3E8; tick();
      Dout_rdy = 0; Din_vld = 0;
      chk("fullpp_level", 32'(Level), 32'd16);
      chk("fullpp_ovf", 32'(Ovf), 32'd1);
`ifdef FIR_DECIM_OVF_CNT_EN
      chk("fullpp_ovfcnt", 32'(OvfCnt), 32'd4);
`endif

      // Clear in a non-drop cycle, then clear across a drop cycle
      Ovf_clr = 1; tick();
      Ovf_clr = 0;
      chk("clr_ovf", 32'(Ovf), 32'd0);
`ifdef FIR_DECIM_OVF_CNT_EN
      chk("clr_ovfcnt", 32'(OvfCnt), 32'd0);
`endif
      Ovf_clr = 1;
      for (int i = 0; i < 4; i++) begin
         Din = DW'(700 + i); Din_vld = 1; tick();
      end
      Ovf_clr = 0; Din_vld = 0;
      chk("clrdrop_ovf", 32'(Ovf), 32'd1);
`ifdef FIR_DECIM_OVF_CNT_EN
      chk("clrdrop_ovfcnt", 32'(OvfCnt), 32'd1);
`endif

      // Drain in order without gaps
      Dout_rdy = 1;
      for (int i = 0; i < 16; i++) tick();
      chk("drain_level", 32'(Level), 32'd0);

      // En toggle: fill a little, drop En for 5 cycles while drain continues
      Dout_rdy = 0;
      for (int i = 0; i < 8; i++) begin
         Din = DW'(300 + i); Din_vld = 1; tick();
      end
      En = 0; Dout_rdy = 1;
      for (int i = 0; i < 5; i++) begin
         Din = DW'(400 + i); tick();
      end
      chk("en_off_level", 32'(Level), 32'd0);
      En = 1; Din_vld = 0; tick();
      for (int i = 0; i < 41; i++) begin
         Din = DW'(500 + i); Din_vld = 1; tick();
      end
      Din_vld = 0; tick();
      chk("resettle_drain", 32'(Level), 32'd0);

      // Fill to Level 9, then async reset between edges
      Dout_rdy = 0; n = 0;
      while (sb_q.size() < 9 && n < 200) begin
         Din = DW'(800 + n); Din_vld = 1; tick(); n++;
      end
      Din_vld = 0; tick();
      chk("pre_rst_level", 32'(Level), 32'd9);
      #2 Rst_n = 1'b0;
      #1;
      chk("arst_vld", 32'(Dout_vld), 32'd0);
      chk("arst_level", 32'(Level), 32'd0);
      chk("arst_ovf", 32'(Ovf), 32'd0);
      chk("arst_dout", 32'(Dout), 32'd0);
      model_reset();
      En = 0;
      tick();
      Rst_n = 1'b1;
      tick();

      // DECIM=1, SETTLE=0 instance: every Din emitted
      En1 = 1; Dout_rdy1 = 1; pops1 = 0; tick();
      for (int i = 0; i < 10; i++) begin
         Din1 = DW'(7 * i + 3); Din_vld1 = 1; tick();
      end
      Din_vld1 = 0;
      for (int i = 0; i < 3; i++) tick();
      chk("passthru_count", 32'(pops1), 32'd10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
